// File: rtl/y_sram_pkg.sv
// Shared Y SRAM geometry, change-entry payload and writer state encoding.
// The address decoder uses the same widths.
package y_sram_pkg;

    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned ROW_W      = 256;
    localparam int unsigned SLOT_W     = 16;
    localparam int unsigned NUM_SLOTS  = ROW_W / SLOT_W;
    localparam int unsigned SLOT_SEL_W = 4;
    localparam int unsigned CHG_W      = 16;
    localparam int unsigned CNT_W      = 16;

    localparam logic [SLOT_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SLOT_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WT   = 2'd2,
        WR   = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]     row;
        logic [SLOT_SEL_W-1:0] slot;
        logic [SLOT_W-1:0]     data;
        logic                  mode;
    } chg_entry_t;

    // Signed 16-bit add clamped to the representable range.
    function automatic logic [SLOT_W-1:0] sat_add(input logic [SLOT_W-1:0] a,
                                                  input logic [SLOT_W-1:0] b);
        logic [SLOT_W:0] sum;
        sum = {a[SLOT_W-1], a} + {b[SLOT_W-1], b};
        if (sum[SLOT_W] != sum[SLOT_W-1]) begin
            return sum[SLOT_W] ? SAT_MIN : SAT_MAX;
        end
        return sum[SLOT_W-1:0];
    endfunction

endpackage

// File: rtl/y_slot_merge.sv
// Replaces or saturating-accumulates one 16-bit slot of a Y SRAM row.
module y_slot_merge
    import y_sram_pkg::*;
(
    input  logic [ROW_W-1:0]      row_i,
    input  logic [SLOT_SEL_W-1:0] slot_i,
    input  logic [SLOT_W-1:0]     value_i,
    input  logic                  mode_i,
    output logic [ROW_W-1:0]      merged_o
);

    logic [SLOT_W-1:0] old_slot;
    logic [SLOT_W-1:0] new_slot;

    always_comb begin
        old_slot = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (slot_i == SLOT_SEL_W'(k)) begin
                old_slot = row_i[k*SLOT_W +: SLOT_W];
            end
        end
        new_slot = mode_i ? sat_add(old_slot, value_i) : value_i;

        merged_o = row_i;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (slot_i == SLOT_SEL_W'(k)) begin
                merged_o[k*SLOT_W +: SLOT_W] = new_slot;
            end
        end
    end

endmodule

// File: rtl/y_row_writer.sv
// Applies change entries to the Y SRAM by read-modify-write of one 256-bit row.
// One update every four cycles; out-of-range columns are dropped and flagged.
module y_row_writer
    import y_sram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chg_valid_i,
    output logic              chg_ready_o,
    input  logic [CHG_W-1:0]  chg_row_i,
    input  logic [CHG_W-1:0]  chg_col_i,
    input  logic [CHG_W-1:0]  chg_data_i,
    input  logic              chg_mode_i,
    output logic              ysram_rd_en_o,
    output logic [ADDR_W-1:0] ysram_rd_addr_o,
    input  logic [ROW_W-1:0]  ysram_rd_data_i,
    output logic              ysram_wr_en_o,
    output logic [ADDR_W-1:0] ysram_wr_addr_o,
    output logic [ROW_W-1:0]  ysram_wr_data_o,
    output logic              upd_done_o,
    output logic [CNT_W-1:0]  upd_count_o,
    output logic              err_col_o
);

    wr_state_e          state_q;
    chg_entry_t         entry_q;
    logic [ROW_W-1:0]   wr_data_q;
    logic [ROW_W-1:0]   merged_d;
    logic [CNT_W-1:0]   upd_count_q;
    logic               err_col_q;
    logic               unused_row_bits;

    assign unused_row_bits = ^chg_row_i[CHG_W-1:ADDR_W];

    y_slot_merge u_merge (
        .row_i    (ysram_rd_data_i),
        .slot_i   (entry_q.slot),
        .value_i  (entry_q.data),
        .mode_i   (entry_q.mode),
        .merged_o (merged_d)
    );

    // Sequencer: IDLE accepts, RD strobes the read, WT captures the merge, WR writes back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            wr_data_q   <= '0;
            upd_count_q <= '0;
            err_col_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chg_valid_i) begin
                        if (|chg_col_i[CHG_W-1:SLOT_SEL_W]) begin
                            err_col_q <= 1'b1;
                        end else begin
                            entry_q <= '{row:  chg_row_i[ADDR_W-1:0],
                                         slot: chg_col_i[SLOT_SEL_W-1:0],
                                         data: chg_data_i,
                                         mode: chg_mode_i};
                            state_q <= RD;
                        end
                    end
                end
                RD: state_q <= WT;
                WT: begin
                    wr_data_q <= merged_d;
                    state_q   <= WR;
                end
                WR: begin
                    upd_count_q <= upd_count_q + CNT_W'(1);
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign chg_ready_o     = (state_q == IDLE);
    assign ysram_rd_en_o   = (state_q == RD);
    assign ysram_wr_en_o   = (state_q == WR);
    assign upd_done_o      = (state_q == WR);
    assign ysram_rd_addr_o = entry_q.row;
    assign ysram_wr_addr_o = entry_q.row;
    assign ysram_wr_data_o = wr_data_q;
    assign upd_count_o     = upd_count_q;
    assign err_col_o       = err_col_q;

endmodule

// File: tb/tb_y_row_writer.sv
// Directed bench for y_row_writer with a behavioural one-cycle-latency Y SRAM.
module tb_y_row_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         chg_valid;
    logic         chg_ready;
    logic [15:0]  chg_row, chg_col, chg_data;
    logic         chg_mode;
    logic         rd_en, wr_en;
    logic [10:0]  rd_addr, wr_addr;
    logic [255:0] rd_data, wr_data;
    logic         upd_done;
    logic [15:0]  upd_count;
    logic         err_col;

    logic [255:0] mem [0:2047];
    logic         pl_en;
    logic [10:0]  pl_addr;
    logic [255:0] pl_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int acc_n    = 0;
    int acc_last = 0;
    int acc_prev = 0;

    always #5 clk = ~clk;

    y_row_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .chg_valid_i     (chg_valid),
        .chg_ready_o     (chg_ready),
        .chg_row_i       (chg_row),
        .chg_col_i       (chg_col),
        .chg_data_i      (chg_data),
        .chg_mode_i      (chg_mode),
        .ysram_rd_en_o   (rd_en),
        .ysram_rd_addr_o (rd_addr),
        .ysram_rd_data_i (rd_data),
        .ysram_wr_en_o   (wr_en),
        .ysram_wr_addr_o (wr_addr),
        .ysram_wr_data_o (wr_data),
        .upd_done_o      (upd_done),
        .upd_count_o     (upd_count),
        .err_col_o       (err_col)
    );

    // SRAM model plus strobe and accept monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_cnt  <= rd_cnt + 1;
        end
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (rst_n && chg_valid && chg_ready) begin
            acc_n    <= acc_n + 1;
            acc_prev <= acc_last;
            acc_last <= cyc;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] addr, input logic [255:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    // Offer one entry and return in the cycle after the accepting edge.
    task automatic apply(input logic [15:0] row, input logic [15:0] col,
                         input logic [15:0] data, input logic mode);
        int n = 0;
        while (!chg_ready && n < 20) begin
            tick();
            n++;
        end
        if (!chg_ready) check("ready_timeout", 256'(chg_ready), 256'(1));
        chg_row   = row;
        chg_col   = col;
        chg_data  = data;
        chg_mode  = mode;
        chg_valid = 1'b1;
        tick();
        chg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!chg_ready && n < 20) begin
            tick();
            n++;
        end
        if (!chg_ready) check("idle_timeout", 256'(chg_ready), 256'(1));
    endtask

    initial begin
        logic [255:0] exp_row;
        logic [255:0] cur;
        int           wr_base;
        int           rd_base;
        int           acc_base;
        logic [15:0]  cnt_base;

        rst_n     = 1'b0;
        chg_valid = 1'b0;
        chg_row   = '0;
        chg_col   = '0;
        chg_data  = '0;
        chg_mode  = 1'b0;
        pl_en     = 1'b0;
        pl_addr   = '0;
        pl_data   = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready",   256'(chg_ready), 256'(1));
        check("rst_rd_en",   256'(rd_en),     256'(0));
        check("rst_wr_en",   256'(wr_en),     256'(0));
        check("rst_rd_addr", 256'(rd_addr),   256'(0));
        check("rst_wr_addr", 256'(wr_addr),   256'(0));
        check("rst_wr_data", wr_data,         256'(0));
        check("rst_done",    256'(upd_done),  256'(0));
        check("rst_count",   256'(upd_count), 256'(0));
        check("rst_err",     256'(err_col),   256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Replace slot 3 of row 5 with exact cycle timing
        preload(11'd5, {16{16'h1111}});
        preload(11'd7, 256'(0));
        preload(11'd3, {16{16'h0101}});
        preload(11'd20, 256'(0));
        cur = 256'(0);
        cur[15:0]  = 16'h7FF0;
        cur[31:16] = 16'h8005;
        cur[47:32] = 16'h0010;
        preload(11'd9, cur);
        wr_base = wr_cnt;
        apply(16'd5, 16'd3, 16'hABCD, 1'b0);
        check("t1_rd_en",    256'(rd_en),     256'(1));
        check("t1_rd_addr",  256'(rd_addr),   256'(5));
        check("t1_ready",    256'(chg_ready), 256'(0));
        tick();
        check("t2_rd_en",    256'(rd_en),     256'(0));
        check("t2_wr_en",    256'(wr_en),     256'(0));
        tick();
        exp_row = {16{16'h1111}};
        exp_row[63:48] = 16'hABCD;
        check("t3_wr_en",    256'(wr_en),     256'(1));
        check("t3_done",     256'(upd_done),  256'(1));
        check("t3_wr_addr",  256'(wr_addr),   256'(5));
        check("t3_wr_data",  wr_data,         exp_row);
        check("t3_count",    256'(upd_count), 256'(0));
        tick();
        check("t4_ready",    256'(chg_ready), 256'(1));
        check("t4_wr_en",    256'(wr_en),     256'(0));
        check("t4_done",     256'(upd_done),  256'(0));
        check("t4_count",    256'(upd_count), 256'(1));
        check("t4_mem5",     mem[5],          exp_row);
        check("t4_one_wr",   256'(wr_cnt - wr_base), 256'(1));

        // Accumulate with positive/negative saturation and a plain add
        apply(16'd9, 16'd0, 16'h0020, 1'b1);
        wait_idle();
        apply(16'd9, 16'd1, 16'hFFF0, 1'b1);
        wait_idle();
        apply(16'd9, 16'd2, 16'hFFF8, 1'b1);
        wait_idle();
        cur = mem[9];
        check("acc_sat_pos", 256'(cur[15:0]),  256'(16'h7FFF));
        check("acc_sat_neg", 256'(cur[31:16]), 256'(16'h8000));
        check("acc_plain",   256'(cur[47:32]), 256'(16'h0008));
        check("acc_other",   256'(cur[255:48]), 256'(0));
        check("acc_count",   256'(upd_count),  256'(4));

        // Out-of-range column is rejected without touching the SRAM
        rd_base  = rd_cnt;
        wr_base  = wr_cnt;
        cnt_base = upd_count;
        apply(16'd5, 16'h0010, 16'h1234, 1'b0);
        check("bad_ready",   256'(chg_ready), 256'(1));
        check("bad_err",     256'(err_col),   256'(1));
        check("bad_rd_en",   256'(rd_en),     256'(0));
        repeat (4) tick();
        check("bad_no_rd",   256'(rd_cnt - rd_base), 256'(0));
        check("bad_no_wr",   256'(wr_cnt - wr_base), 256'(0));
        check("bad_count",   256'(upd_count), 256'(cnt_base));
        check("bad_sticky",  256'(err_col),   256'(1));

        // Back-to-back accumulates to the same row with valid held high
        acc_base  = acc_n;
        chg_row   = 16'd7;
        chg_col   = 16'd15;
        chg_data  = 16'h0001;
        chg_mode  = 1'b1;
        chg_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_n >= acc_base + 2) break;
        end
        chg_valid = 1'b0;
        check("b2b_accepts", 256'(acc_n - acc_base), 256'(2));
        check("b2b_gap",     256'(acc_last - acc_prev), 256'(4));
        wait_idle();
        tick();
        check("b2b_slot15",  256'(mem[7][255:240]), 256'(16'h0002));
        check("b2b_rest",    256'(mem[7][239:0]),   256'(0));

        // Reset during the read cycle drops the update
        wr_base = wr_cnt;
        apply(16'd3, 16'd4, 16'h0F0F, 1'b0);
        check("rrd_rd_en",   256'(rd_en), 256'(1));
        rst_n = 1'b0;
        #1;
        check("rrd_ready",   256'(chg_ready), 256'(1));
        check("rrd_rd_en0",  256'(rd_en),     256'(0));
        check("rrd_rd_addr", 256'(rd_addr),   256'(0));
        check("rrd_count",   256'(upd_count), 256'(0));
        check("rrd_err",     256'(err_col),   256'(0));
        check("rrd_wr_data", wr_data,         256'(0));
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("rrd_no_wr",   256'(wr_cnt - wr_base), 256'(0));
        check("rrd_mem3",    mem[3], {16{16'h0101}});
        apply(16'd3, 16'd4, 16'h0F0F, 1'b0);
        wait_idle();
        tick();
        exp_row = {16{16'h0101}};
        exp_row[79:64] = 16'h0F0F;
        check("rrd_after",   mem[3], exp_row);
        check("rrd_cnt1",    256'(upd_count), 256'(1));

        // Counter wrap, preloaded near the top through a backdoor
        force dut.upd_count_q = 16'hFFFE;
        tick();
        release dut.upd_count_q;
        tick();
        check("wrap_pre",    256'(upd_count), 256'(16'hFFFE));
        apply(16'd20, 16'd0, 16'h0001, 1'b0);
        wait_idle();
        check("wrap_ffff",   256'(upd_count), 256'(16'hFFFF));
        apply(16'd20, 16'd1, 16'h0002, 1'b0);
        wait_idle();
        check("wrap_zero",   256'(upd_count), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/y_row_writer.md
# y_row_writer

Write-side companion to the Y-matrix address decoder: takes one change entry at a time (row, column, 16-bit value, mode) and updates the Y SRAM by read-modify-write of the addressed 256-bit row. The Y SRAM row holds sixteen 16-bit slots. Sits between the change-file feeder and the Y SRAM port, so the decoder reads rows that already reflect applied changes.

## Interface
Parameters:
- ADDR_W, 11, Y SRAM row address width
- ROW_W, 256, Y SRAM row width
- SLOT_W, 16, slot width; ROW_W/SLOT_W = 16 slots per row

Ports:
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- chg_valid  in  1  change entry offered
- chg_ready  out  1  writer can accept; high only in IDLE
- chg_row  in  16  target row; bits [10:0] form the SRAM address
- chg_col  in  16  target column; bits [3:0] select the slot
- chg_data  in  16  value, signed two's complement
- chg_mode  in  1  0 = replace slot, 1 = accumulate (saturating add)
- ysram_rd_en  out  1  SRAM read strobe
- ysram_rd_addr  out  ADDR_W  SRAM read address
- ysram_rd_data  in  ROW_W  SRAM read data, valid the cycle after ysram_rd_en
- ysram_wr_en  out  1  SRAM write strobe
- ysram_wr_addr  out  ADDR_W  SRAM write address
- ysram_wr_data  out  ROW_W  merged row
- upd_done  out  1  one-cycle pulse when a write is issued
- upd_count  out  16  completed-write counter
- err_col  out  1  sticky: an entry had chg_col[15:4] nonzero

## Operation
- States: IDLE, RD, WT, WR.
- IDLE: chg_ready=1. On chg_valid: register row[10:0], col[3:0], data, mode; check col[15:4]. If nonzero -> set err_col, discard entry, stay IDLE (no SRAM access). Otherwise -> RD.
- RD: ysram_rd_en=1, ysram_rd_addr=registered row -> WT.
- WT: capture ysram_rd_data; build merged row: slots other than the selected slot unchanged; selected slot = data (mode 0) or sat(old + data) (mode 1). Register into ysram_wr_data -> WR.
- WR: ysram_wr_en=1, ysram_wr_addr=registered row, upd_done=1, upd_count increments -> IDLE.
- Slot k occupies bits [16k+15:16k].
- Saturating add: 17-bit signed sum; >32767 -> 16'h7FFF; <-32768 -> 16'h8000; otherwise low 16 bits.
- upd_count wraps 16'hFFFF -> 0.
- err_col cleared only by reset.
- Back-to-back entries to the same row are safe: each RMW completes its write before the next read.

## Timing
- Reset values: chg_ready=1 (state IDLE), ysram_rd_en=0, ysram_wr_en=0, rd/wr addresses 0, ysram_wr_data 0, upd_done=0, upd_count=0, err_col=0.
- All outputs registered or decoded from state registers; no combinational path from chg_* to SRAM strobes.
- Accept at edge T -> rd_en high in cycle T+1 -> data captured at T+2 -> wr_en and upd_done high in cycle T+3 -> chg_ready high again in cycle T+4.
- Throughput: one update per 4 cycles. Rejected (err_col) entry consumes 1 cycle.
- chg_valid while chg_ready=0 is ignored; the feeder holds it.
- Reset mid-operation: the in-flight update is dropped. If reset asserts during WR, the write strobe deasserts asynchronously. No partial write is retried.

## Structure
- Shared package y_sram_pkg: ADDR_W, ROW_W, SLOT_W, NUM_SLOTS, SLOT_SEL_W=4, state enum {IDLE, RD, WT, WR}, SAT_MAX/SAT_MIN constants. The address decoder uses the same widths.
- One sub-module, y_slot_merge: combinational row + slot index + value + mode -> merged row, including saturation. The FSM, counter and error flag live in y_row_writer.

## Test plan
- Replace: row 5 preloaded all 16'h1111, entry (row 5, col 3, 16'hABCD, mode 0) -> single write to addr 5, slot 3 = ABCD, other slots 1111; upd_done pulses at T+3; upd_count=1.
- Accumulate and saturate: slot 0 = 16'h7FF0, add 16'h0020 -> 16'h7FFF. Slot 1 = 16'h8005, add 16'hFFF0 -> 16'h8000. Slot 2 = 16'h0010, add 16'hFFF8 -> 16'h0008.
- Bad column: col 16'h0010 -> no rd_en or wr_en, err_col=1 and stays set, upd_count unchanged, chg_ready back high the next cycle.
- Back-to-back, same row: two accumulate entries of +1 to row 7 slot 15, initial 0, chg_valid held high -> final slot value 2; accepts 4 cycles apart.
- Reset at the RD cycle: no wr_en ever issued, all outputs return to reset values, and the next entry completes normally.
- Counter wrap: force 65536 updates (or preload via a backdoor) -> upd_count reads 0 after the 65536th.
